// File: rtl/jenkins_oaat_wide.sv
// Multi-byte Jenkins one-at-a-time hash: up to BYTES rounds per accepted beat,
// one finalise cycle per message, result held until the next message completes.
//
// state | meaning
// ACCUM | accepting beats, folding bytes into h and counting len
// FIN   | one cycle: finalise h into hash, pulse hash_valid, reload seed
module jenkins_oaat_wide #(
    parameter int          BYTES = 4,
    parameter logic [31:0] SEED  = 32'h0000_0000,
    parameter int          CW    = $clog2(BYTES + 1)
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BYTES*8-1:0] in_data,
    input  logic [CW-1:0]      in_count,
    input  logic               in_last,
    output logic               hash_valid,
    output logic [31:0]        hash,
    output logic [15:0]        hash_length
);

    typedef enum logic {ACCUM, FIN} state_t;

    localparam logic [CW-1:0] FULL = CW'(BYTES);

    state_t      state, state_nxt;
    logic [31:0] h_q, h_mix, g1, g2, fin_h;
    logic [15:0] len_q, len_nxt;
    logic [16:0] len_sum;
    logic [CW-1:0] n_apply;
    logic        accept;

    always_comb begin
        n_apply = (in_count > FULL) ? FULL : in_count;
    end

    // All rounds of one beat form a single combinational chain, byte 0 first.
    always_comb begin
        h_mix = h_q;
        for (int k = 0; k < BYTES; k++) begin
            if (k < int'(n_apply)) begin
                h_mix = h_mix + 32'(in_data[8*k +: 8]);
                h_mix = h_mix + (h_mix << 10);
                h_mix = h_mix ^ (h_mix >> 6);
            end
        end
    end

    always_comb begin
        len_sum = {1'b0, len_q} + 17'(n_apply);
        len_nxt = len_sum[16] ? 16'hFFFF : len_sum[15:0];
    end

    always_comb begin
        g1    = h_q + (h_q << 3);
        g2    = g1 ^ (g1 >> 11);
        fin_h = g2 + (g2 << 15);
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ACCUM: if (accept && in_last) state_nxt = FIN;
            FIN:   state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    always_comb begin
        in_ready = (state == ACCUM);
        accept   = in_valid && in_ready;
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            h_q         <= SEED;
            len_q       <= 16'd0;
            hash        <= 32'd0;
            hash_length <= 16'd0;
            hash_valid  <= 1'b0;
        end else begin
            hash_valid <= 1'b0;
            unique case (state)
                ACCUM: begin
                    if (accept) begin
                        h_q   <= h_mix;
                        len_q <= len_nxt;
                    end
                end
                FIN: begin
                    hash        <= fin_h;
                    hash_length <= len_q;
                    hash_valid  <= 1'b1;
                    h_q         <= SEED;
                    len_q       <= 16'd0;
                end
                default: begin
                    h_q   <= SEED;
                    len_q <= 16'd0;
                end
            endcase
        end
    end

endmodule
